// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: walks {A,B,C,D} through all 16 vectors and checks the
// F_0..F_2 outputs of a K-map block against parameterised truth tables.
// Latency: done pulses 16*SETTLE+1 cycles after the accepting start cycle.
// Backpressure: none; start is ignored outside IDLE, abort only acts in RUN.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, abort          begin a sweep / cancel a running sweep
//   A, B, C, D            stimulus vector, A = MSB, D = LSB
//   F_0, F_1, F_2         K-map outputs under test
//   busy, done, pass      in RUN / one-cycle completion pulse / zero-failure flag
//   err_cnt               failing vectors in the last sweep (0..16)
//   first_fail_idx        index of first failing vector (error log only)
//   fail_mask             OR of {F_2,F_1,F_0} mismatch bits (error log only)
//
// Optional feature: define KMAP_SWEEP_ERRLOG_EN to build the error-log
// registers behind first_fail_idx / fail_mask; otherwise both read as 0.

module kmap_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter logic [15:0] EXP_F0 = 16'h6996,
  parameter logic [15:0] EXP_F1 = 16'hEDE0,
  parameter logic [15:0] EXP_F2 = 16'hD1CC,
  parameter logic [15:0] DC_F2  = 16'h2222
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       F_0,
  input  logic       F_1,
  input  logic       F_2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail_idx,
  output logic [2:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last settle-count value: the cycle on which the held vector is judged.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic [4:0] err_q;
  logic       pass_q;

  logic       last_tick;
  logic       compare;
  logic       last_vec;
  logic [2:0] mm;
  logic       vec_fail;
  logic [4:0] err_nxt;

  // Mismatch per output; F_2 ignores vectors marked don't-care.
  always_comb begin
    mm       = 3'b000;
    mm[0]    = (F_0 != EXP_F0[idx]);
    mm[1]    = (F_1 != EXP_F1[idx]);
    mm[2]    = (F_2 != EXP_F2[idx]) & ~DC_F2[idx];
    vec_fail = |mm;
  end

  assign last_tick = (settle_cnt == SETTLE_LAST);
  assign compare   = (state == RUN) && last_tick;
  assign last_vec  = (idx == 4'd15);
  // One increment per failing vector regardless of how many outputs differ.
  assign err_nxt   = err_q + {4'd0, (compare && vec_fail)};

  // Next-state logic; abort wins over completion of vector 15.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (abort)                  state_nxt = IDLE;
        else if (compare && last_vec) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: vector index, settle counter, error count and pass flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 4'd0;
      settle_cnt <= 4'd0;
      err_q      <= 5'd0;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            err_q      <= 5'd0;
            pass_q     <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            pass_q     <= 1'b0;
          end else if (last_tick) begin
            settle_cnt <= 4'd0;
            err_q      <= err_nxt;
            if (last_vec) begin
              // Return the stimulus to 0 rather than wrapping into a new sweep.
              idx    <= 4'd0;
              pass_q <= (err_nxt == 5'd0);
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: begin
          idx        <= 4'd0;
          settle_cnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef KMAP_SWEEP_ERRLOG_EN
  logic [3:0] ffi_q;
  logic [2:0] fm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffi_q <= 4'd0;
      fm_q  <= 3'd0;
    end else if (state == IDLE && start) begin
      ffi_q <= 4'd0;
      fm_q  <= 3'd0;
    end else if (compare && !abort && vec_fail) begin
      // err_q still zero means this is the first failing vector of the sweep.
      if (err_q == 5'd0) ffi_q <= idx;
      fm_q <= fm_q | mm;
    end
  end

  assign first_fail_idx = ffi_q;
  assign fail_mask      = fm_q;
`else
  assign first_fail_idx = 4'd0;
  assign fail_mask      = 3'd0;
`endif

  assign A       = idx[3];
  assign B       = idx[2];
  assign C       = idx[1];
  assign D       = idx[0];
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// each driven by a small K-map model with selectable fault injection.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_kmap_sweep_ctrl;

  localparam logic [15:0] KM_F0 = 16'h6996;
  localparam logic [15:0] KM_F1 = 16'hEDE0;
  localparam logic [15:0] KM_F2 = 16'hD1CC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start0 = 1'b0, abort0 = 1'b0;
  logic a0, b0, c0, d0, f0_0, f1_0, f2_0;
  logic busy0, done0, pass0;
  logic [4:0] err0;
  logic [3:0] ffi0;
  logic [2:0] fm0;
  int mode0 = 0;  // 0 good, 1 F_0 stuck at 0, 2 F_2 inverted on vectors 1,5,9,13

  logic start1 = 1'b0, abort1 = 1'b0;
  logic a1, b1, c1, d1, f0_1, f1_1, f2_1;
  logic busy1, done1, pass1;
  logic [4:0] err1;
  logic [3:0] ffi1;
  logic [2:0] fm1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kmap_sweep_ctrl #(.SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .A(a0), .B(b0), .C(c0), .D(d0),
    .F_0(f0_0), .F_1(f1_0), .F_2(f2_0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_fail_idx(ffi0), .fail_mask(fm0)
  );

  kmap_sweep_ctrl #(.SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .F_0(f0_1), .F_1(f1_1), .F_2(f2_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_fail_idx(ffi1), .fail_mask(fm1)
  );

  // K-map models driven by each DUT's stimulus.
  always_comb begin
    logic [3:0] v;
    v    = {a0, b0, c0, d0};
    f0_0 = KM_F0[v];
    f1_0 = KM_F1[v];
    f2_0 = KM_F2[v];
    if (mode0 == 1) f0_0 = 1'b0;
    if (mode0 == 2 && v[1:0] == 2'b01) f2_0 = ~KM_F2[v];
  end

  always_comb begin
    logic [3:0] v;
    v    = {a1, b1, c1, d1};
    f0_1 = KM_F0[v];
    f1_1 = KM_F1[v];
    f2_1 = KM_F2[v];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Full sweep on dut0. Cycle n=1 is the first cycle after the accepting edge;
  // returns the cycle in which done was seen (0 if never) and busy cycle count.
  task automatic sweep0(output int done_n, output int busy_n);
    done_n = 0;
    busy_n = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int n = 1; n <= 40 && done_n == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy0) busy_n++;
      if (done0) done_n = n;
    end
  endtask

  initial begin
    int dn, bn;

    // Reset state
    #12;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_abcd", {a0, b0, c0, d0}, 0);
    chk("rst_ffi", ffi0, 0);
    chk("rst_fm", fm0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Good model, SETTLE=1
    mode0 = 0;
    sweep0(dn, bn);
    chk("good_done_lat", dn, 17);
    chk("good_busy_cyc", bn, 16);
    chk("good_pass", pass0, 1);
    chk("good_err", err0, 0);
    chk("good_abcd_done", {a0, b0, c0, d0}, 0);
    @(negedge clk);
    chk("good_done_pulse", done0, 0);

    // F_0 stuck at 0
    mode0 = 1;
    sweep0(dn, bn);
    chk("f0sa_done_lat", dn, 17);
    chk("f0sa_pass", pass0, 0);
    chk("f0sa_err", err0, 8);
`ifdef KMAP_SWEEP_ERRLOG_EN
    chk("f0sa_ffi", ffi0, 1);
    chk("f0sa_fm", fm0, 3'b001);
`else
    chk("f0sa_ffi", ffi0, 0);
    chk("f0sa_fm", fm0, 0);
`endif
    // Results hold in IDLE; abort outside RUN does nothing
    mode0 = 0;
    @(negedge clk); abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    @(negedge clk);
    chk("hold_err", err0, 8);
    chk("hold_pass", pass0, 0);
    chk("idle_abort_busy", busy0, 0);

    // F_2 wrong only on don't-care vectors
    mode0 = 2;
    sweep0(dn, bn);
    chk("dc_done_lat", dn, 17);
    chk("dc_pass", pass0, 1);
    chk("dc_err", err0, 0);
    mode0 = 0;

    // Abort while vector 5 is driven
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;        // n=1, vector 0
    chk("abort_start_err", err0, 0);
    repeat (5) @(negedge clk);             // n=6, vector 5
    chk("abort_vec5", {a0, b0, c0, d0}, 5);
    abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_pass", pass0, 0);
    chk("abort_abcd", {a0, b0, c0, d0}, 0);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) dn++;
    end
    chk("abort_quiet", dn, 0);
    sweep0(dn, bn);
    chk("post_abort_lat", dn, 17);
    chk("post_abort_pass", pass1 | pass0, 1);

    // SETTLE=3 with a re-pulsed start while busy
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;        // n=1
    dn = 0; bn = 0;
    for (int n = 1; n <= 80 && dn == 0; n++) begin
      if (n > 1) @(negedge clk);
      start1 = (n == 2);
      if (n == 4) chk("s3_vec1", {a1, b1, c1, d1}, 1);
      if (busy1) bn++;
      if (done1) dn = n;
    end
    start1 = 1'b0;
    chk("s3_done_lat", dn, 49);
    chk("s3_busy_cyc", bn, 48);
    chk("s3_pass", pass1, 1);

    // Async reset at vector 9
    mode0 = 1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;        // n=1
    repeat (9) @(negedge clk);             // n=10, vector 9
    chk("rst_mid_vec9", {a0, b0, c0, d0}, 9);
    chk("rst_mid_err_pre", err0 != 0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_abcd", {a0, b0, c0, d0}, 0);
    chk("rst_mid_err", err0, 0);
    chk("rst_mid_pass", pass0, 0);
    chk("rst_mid_done", done0, 0);
    mode0 = 0;
    @(negedge clk); rst_n = 1'b1; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("rst_first_start", busy0, 1);
    chk("rst_restart_vec0", {a0, b0, c0, d0}, 0);
    dn = 0;
    for (int n = 2; n <= 40 && dn == 0; n++) begin
      @(negedge clk);
      if (done0) dn = n;
    end
    chk("rst_restart_lat", dn, 17);
    chk("rst_restart_pass", pass0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
